// File: rtl/alu_pkg.sv
// Shared definitions for the register-file/ALU execute block:
// opcodes, datapath widths and saturation limits.
package alu_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 4;
  localparam int LANE_W    = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NAND = 3'b010,
    OP_XOR  = 3'b011,
    OP_PADD = 3'b100,
    OP_RED  = 3'b101
  } opcode_e;

  localparam logic [15:0] SAT_POS16 = 16'h7FFF;
  localparam logic [15:0] SAT_NEG16 = 16'h8000;
  localparam logic [3:0]  SAT_POS4  = 4'h7;
  localparam logic [3:0]  SAT_NEG4  = 4'h8;

endpackage

// File: rtl/lane_add4.sv
// 4-bit carry-lookahead adder lane with subtract, carry-out and signed overflow.
// Lanes run independently for nibble ops or chain through carry_in/carry_out.
module lane_add4 (
  input  logic       clk_unused,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out,
  output logic       overflow
);

  logic [3:0] bx;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign bx = b ^ {4{sub}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  // Every carry is expanded from generate/propagate terms, so no internal ripple.
  assign c[0] = carry_in;
  assign c[1] = g[0] | (p[0] & carry_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry_in);

  assign sum       = p ^ c[3:0];
  assign carry_out = c[4];
  // Carry into and out of the sign bit differ exactly when same-sign inputs flip sign.
  assign overflow  = c[4] ^ c[3];

endmodule

// File: rtl/alu_regfile_unit.sv
// Single-cycle execute block: register file with two combinational read
// ports feeding a saturating ALU whose result can be written back.
module alu_regfile_unit
  import alu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] src_reg1,
  input  logic [REG_IDX_W-1:0] src_reg2,
  input  logic [REG_IDX_W-1:0] dst_reg,
  input  logic                 write_reg,
  input  logic [2:0]           opcode,
  output logic [DATA_W-1:0]    src_data1,
  output logic [DATA_W-1:0]    src_data2,
  output logic [DATA_W-1:0]    alu_out,
  output logic                 error
);

  function automatic logic signed [DATA_W-1:0] sat16(
    input logic signed [DATA_W-1:0] s,
    input logic                     ovf,
    input logic                     neg
  );
    if (!ovf) return s;
    return neg ? SAT_NEG16 : SAT_POS16;
  endfunction

  function automatic logic [LANE_W-1:0] sat4(
    input logic [LANE_W-1:0] s,
    input logic              ovf,
    input logic              neg
  );
    if (!ovf) return s;
    return neg ? SAT_NEG4 : SAT_POS4;
  endfunction

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic signed [DATA_W-1:0] sum;
  logic signed [DATA_W-1:0] res;
  logic                     err;
  logic                     chain;
  logic                     sub;
  logic                     c1, c2, c3, carry_unused;
  logic                     v0, v1, v2, v3;
  logic [3:0]               ovf;

  // Reads come from stored state only; R0 is hard-wired to zero.
  assign a = (src_reg1 == '0) ? '0 : regs[src_reg1];
  assign b = (src_reg2 == '0) ? '0 : regs[src_reg2];

  assign chain = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign sub   = (opcode == OP_SUB);

  lane_add4 u_lane0 (
    .clk_unused(clk), .a(a[3:0]), .b(b[3:0]), .sub(sub), .carry_in(sub),
    .sum(sum[3:0]), .carry_out(c1), .overflow(v0)
  );
  lane_add4 u_lane1 (
    .clk_unused(clk), .a(a[7:4]), .b(b[7:4]), .sub(sub), .carry_in(chain & c1),
    .sum(sum[7:4]), .carry_out(c2), .overflow(v1)
  );
  lane_add4 u_lane2 (
    .clk_unused(clk), .a(a[11:8]), .b(b[11:8]), .sub(sub), .carry_in(chain & c2),
    .sum(sum[11:8]), .carry_out(c3), .overflow(v2)
  );
  lane_add4 u_lane3 (
    .clk_unused(clk), .a(a[15:12]), .b(b[15:12]), .sub(sub), .carry_in(chain & c3),
    .sum(sum[15:12]), .carry_out(carry_unused), .overflow(v3)
  );

  assign ovf = {v3, v2, v1, v0};

  always_comb begin
    res = '0;
    err = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        // Overflow direction follows A's sign: effective operands share it.
        res = sat16(sum, v3, a[DATA_W-1]);
        err = v3;
      end
      OP_NAND: res = ~(a & b);
      OP_XOR:  res = a ^ b;
      OP_PADD: begin
        for (int i = 0; i < 4; i++)
          res[LANE_W*i +: LANE_W] = sat4(sum[LANE_W*i +: LANE_W], ovf[i], a[LANE_W*i+3]);
        err = |ovf;
      end
      OP_RED:  res = sum;
      default: res = '0;
    endcase
  end

  assign src_data1 = rst ? a   : '0;
  assign src_data2 = rst ? b   : '0;
  assign alu_out   = rst ? res : '0;
  assign error     = rst ? err : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_reg && (dst_reg != '0)) begin
      regs[dst_reg] <= res;
    end
  end

endmodule

// File: tb/tb_alu_regfile_unit.sv
// Scoreboard bench for alu_regfile_unit: registers are preloaded through the
// ALU itself, expectations come from constants and an independent integer model.
module tb_alu_regfile_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  src_reg1 = '0;
  logic [3:0]  src_reg2 = '0;
  logic [3:0]  dst_reg = '0;
  logic        write_reg = 1'b0;
  logic [2:0]  opcode = '0;
  logic [15:0] src_data1;
  logic [15:0] src_data2;
  logic [15:0] alu_out;
  logic        error;

  always #5 clk = ~clk;

  alu_regfile_unit dut (
    .clk(clk), .rst(rst), .src_reg1(src_reg1), .src_reg2(src_reg2),
    .dst_reg(dst_reg), .write_reg(write_reg), .opcode(opcode),
    .src_data1(src_data1), .src_data2(src_data2), .alu_out(alu_out), .error(error)
  );

  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] out;
    logic        err;
  } obs_t;

  obs_t        sbq[$];
  logic [15:0] shadow [16];
  int          errors = 0;
  int          checks = 0;

  logic [2:0]  t_op  [14] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd4, 3'd4, 3'd5,
                              3'd5, 3'd2, 3'd3, 3'd1, 3'd0, 3'd6, 3'd7};
  logic [15:0] t_a   [14] = '{16'h7FFF, 16'h8800, 16'h8000, 16'h0000, 16'h8009,
                              16'h0FD8, 16'h1111, 16'hF111, 16'h1234, 16'h1234,
                              16'h7FFF, 16'h1234, 16'h1234, 16'hFFFF};
  logic [15:0] t_b   [14] = '{16'h0001, 16'h8901, 16'h0001, 16'h0000, 16'h9009,
                              16'h0019, 16'h1111, 16'hF111, 16'hFF00, 16'hFF00,
                              16'hFFFF, 16'h0001, 16'h5678, 16'hFFFF};
  logic [15:0] t_out [14] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h8008,
                              16'h0FE8, 16'h2222, 16'hE222, 16'hEDFF, 16'hED34,
                              16'h7FFF, 16'h1235, 16'h0000, 16'h0000};
  logic        t_err [14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  // Returns {error, result} using plain integer arithmetic.
  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int          s;
    int          l;
    logic [15:0] r;
    logic        e;
    r = '0;
    e = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        s = (op == 3'd0) ? int'($signed(a)) + int'($signed(b))
                         : int'($signed(a)) - int'($signed(b));
        if (s > 32767) begin r = 16'h7FFF; e = 1'b1; end
        else if (s < -32768) begin r = 16'h8000; e = 1'b1; end
        else r = s[15:0];
      end
      3'd2: r = ~(a & b);
      3'd3: r = a ^ b;
      3'd4: for (int i = 0; i < 4; i++) begin
        l = int'($signed(a[4*i +: 4])) + int'($signed(b[4*i +: 4]));
        if (l > 7) begin r[4*i +: 4] = 4'h7; e = 1'b1; end
        else if (l < -8) begin r[4*i +: 4] = 4'h8; e = 1'b1; end
        else r[4*i +: 4] = l[3:0];
      end
      3'd5: for (int i = 0; i < 4; i++) r[4*i +: 4] = a[4*i +: 4] + b[4*i +: 4];
      default: r = '0;
    endcase
    return {e, r};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic we);
    logic [16:0] m;
    opcode = op; src_reg1 = s1; src_reg2 = s2; dst_reg = d; write_reg = we;
    m = model(op, shadow[s1], shadow[s2]);
    @(posedge clk); #1;
    if (we && d != 4'd0) shadow[d] = m[15:0];
    write_reg = 1'b0;
  endtask

  // Builds a value by doubling and adding R15 (=1); bit 15 via XOR with R13 (=0x8000).
  task automatic load_reg(input logic [3:0] idx, input logic [15:0] v);
    logic started;
    started = 1'b0;
    drive(3'd3, 4'd0, 4'd0, idx, 1'b1);
    for (int bt = 14; bt >= 0; bt--) begin
      if (started) drive(3'd0, idx, idx, idx, 1'b1);
      if (v[bt]) begin
        drive(3'd0, idx, 4'd15, idx, 1'b1);
        started = 1'b1;
      end
    end
    if (v[15]) drive(3'd3, idx, 4'd13, idx, 1'b1);
  endtask

  task automatic setup_scratch();
    drive(3'd2, 4'd0, 4'd0, 4'd14, 1'b1);
    drive(3'd1, 4'd0, 4'd14, 4'd15, 1'b1);
    load_reg(4'd13, 16'h7FFF);
    drive(3'd2, 4'd13, 4'd13, 4'd13, 1'b1);
  endtask

  task automatic test_reset();
    obs_t exp_v, got;
    opcode = 3'd2; write_reg = 1'b1; dst_reg = 4'd5; src_reg1 = 4'd0; src_reg2 = 4'd0;
    sbq.push_back('{16'h0, 16'h0, 16'h0, 1'b0});
    @(negedge clk);
    got = {src_data1, src_data2, alu_out, error};
    exp_v = sbq.pop_front();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL reset_hold: got %h/%h/%h/%b expected %h/%h/%h/%b",
               got.d1, got.d2, got.out, got.err, exp_v.d1, exp_v.d2, exp_v.out, exp_v.err);
    end
    @(posedge clk); #1;
    write_reg = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      src_reg1 = 4'(i); src_reg2 = 4'(15 - i); opcode = 3'd0;
      sbq.push_back('{16'h0, 16'h0, 16'h0, 1'b0});
      @(negedge clk);
      got = {src_data1, src_data2, alu_out, error};
      exp_v = sbq.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset_read r%0d: got %h/%h/%h/%b expected %h/%h/%h/%b", i,
                 got.d1, got.d2, got.out, got.err, exp_v.d1, exp_v.d2, exp_v.out, exp_v.err);
      end
    end
  endtask

  task automatic test_write_read();
    obs_t exp_v, got;
    logic [3:0] s1 [4] = '{4'd1, 4'd3, 4'd0, 4'd3};
    logic [3:0] s2 [4] = '{4'd2, 4'd0, 4'd3, 4'd0};
    logic [3:0] ds [4] = '{4'd3, 4'd0, 4'd3, 4'd0};
    logic [2:0] op [4] = '{3'd3, 3'd3, 3'd2, 3'd3};
    logic       we [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    obs_t       ev [4] = '{'{16'h1234, 16'h0000, 16'h1234, 1'b0},
                           '{16'h1234, 16'h0000, 16'h1234, 1'b0},
                           '{16'h0000, 16'h1234, 16'hFFFF, 1'b0},
                           '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0}};
    load_reg(4'd1, 16'h1234);
    drive(3'd3, 4'd0, 4'd0, 4'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      opcode = op[i]; src_reg1 = s1[i]; src_reg2 = s2[i]; dst_reg = ds[i]; write_reg = we[i];
      sbq.push_back(ev[i]);
      @(negedge clk);
      got = {src_data1, src_data2, alu_out, error};
      exp_v = sbq.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL write_read step%0d: got %h/%h/%h/%b expected %h/%h/%h/%b", i,
                 got.d1, got.d2, got.out, got.err, exp_v.d1, exp_v.d2, exp_v.out, exp_v.err);
      end
      @(posedge clk); #1;
      write_reg = 1'b0;
    end
    shadow[3] = 16'hFFFF;
  endtask

  task automatic test_alu_directed();
    obs_t exp_v, got;
    for (int i = 0; i < 14; i++) begin
      load_reg(4'd4, t_a[i]);
      load_reg(4'd5, t_b[i]);
      opcode = t_op[i]; src_reg1 = 4'd4; src_reg2 = 4'd5; dst_reg = 4'd6; write_reg = 1'b1;
      sbq.push_back('{t_a[i], t_b[i], t_out[i], t_err[i]});
      @(negedge clk);
      got = {src_data1, src_data2, alu_out, error};
      exp_v = sbq.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL alu_vec%0d op%0d: got %h/%h/%h/%b expected %h/%h/%h/%b", i, t_op[i],
                 got.d1, got.d2, got.out, got.err, exp_v.d1, exp_v.d2, exp_v.out, exp_v.err);
      end
      @(posedge clk); #1;
      write_reg = 1'b0;
      shadow[6] = t_out[i];
      opcode = 3'd3; src_reg1 = 4'd6; src_reg2 = 4'd4;
      sbq.push_back('{t_out[i], t_a[i], t_out[i] ^ t_a[i], 1'b0});
      @(negedge clk);
      got = {src_data1, src_data2, alu_out, error};
      exp_v = sbq.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL writeback_vec%0d: got %h/%h/%h/%b expected %h/%h/%h/%b", i,
                 got.d1, got.d2, got.out, got.err, exp_v.d1, exp_v.d2, exp_v.out, exp_v.err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    obs_t        exp_v, got;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic [16:0] m;
    for (int i = 0; i < 256; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      op = 3'($urandom_range(0, 7));
      load_reg(4'd7, a);
      load_reg(4'd8, b);
      opcode = op; src_reg1 = 4'd7; src_reg2 = 4'd8; write_reg = 1'b0;
      m = model(op, a, b);
      sbq.push_back('{a, b, m[15:0], m[16]});
      @(negedge clk);
      got = {src_data1, src_data2, alu_out, error};
      exp_v = sbq.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random%0d op%0d: got %h/%h/%h/%b expected %h/%h/%h/%b", i, op,
                 got.d1, got.d2, got.out, got.err, exp_v.d1, exp_v.d2, exp_v.out, exp_v.err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    obs_t exp_v, got;
    opcode = 3'd2; src_reg1 = 4'd1; src_reg2 = 4'd4; dst_reg = 4'd9; write_reg = 1'b1;
    #2;
    rst = 1'b0;
    sbq.push_back('{16'h0, 16'h0, 16'h0, 1'b0});
    #1;
    got = {src_data1, src_data2, alu_out, error};
    exp_v = sbq.pop_front();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL reset_async: got %h/%h/%h/%b expected %h/%h/%h/%b",
               got.d1, got.d2, got.out, got.err, exp_v.d1, exp_v.d2, exp_v.out, exp_v.err);
    end
    @(posedge clk); #1;
    write_reg = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = 16'h0;
    for (int i = 0; i < 2; i++) begin
      opcode = 3'd0; src_reg1 = (i == 0) ? 4'd1 : 4'd13; src_reg2 = 4'd9;
      sbq.push_back('{16'h0, 16'h0, 16'h0, 1'b0});
      @(negedge clk);
      got = {src_data1, src_data2, alu_out, error};
      exp_v = sbq.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_read%0d: got %h/%h/%h/%b expected %h/%h/%h/%b", i,
                 got.d1, got.d2, got.out, got.err, exp_v.d1, exp_v.d2, exp_v.out, exp_v.err);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = 16'h0;
    test_reset();
    setup_scratch();
    test_write_read();
    test_alu_directed();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_regfile_unit.md
Name: alu_regfile_unit

Overview:
- Single-cycle execute block containing a 16-entry x 16-bit register file and a 16-bit ALU.
- The two register read ports feed the ALU combinationally. On a rising clk edge with write enable set, the ALU result is written back to the destination register.
- The ALU supports saturating add/sub, NAND, XOR, nibble-parallel saturating add (PADD) and nibble-wise reduction add (RED).

Parameters:
- DATA_W, 16, datapath width; must be a multiple of 4.
- NUM_REGS, 16, register count; register index width is log2(NUM_REGS).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous, active-low.
- src_reg1  input  4  read-port-1 register index.
- src_reg2  input  4  read-port-2 register index.
- dst_reg  input  4  write register index.
- write_reg  input  1  write enable for ALU result into dst_reg.
- opcode  input  3  ALU operation select.
- src_data1  output  16  contents of src_reg1.
- src_data2  output  16  contents of src_reg2.
- alu_out  output  16  ALU result on (src_data1, src_data2).
- error  output  1  overflow/saturation flag for the current opcode.

Behaviour:
- Reset:
  - rst low asynchronously clears all registers to 0x0000.
  - While reset is held, src_data1, src_data2 and alu_out are 0x0000 and error is 0.
  - Reset asserted mid-operation overrides any pending write.
- Reads: combinational, from stored state. There is no write-to-read bypass, which avoids the loop through the ALU. A written value appears on reads after the capturing edge.
- R0: reads always 0x0000; writes to R0 are ignored.
- Write: on posedge clk, when rst is high and write_reg is 1 and dst_reg != 0, reg[dst_reg] <= alu_out.
- ALU: purely combinational, operands A = src_data1, B = src_data2, two's complement.
  - 000 ADD: A+B, saturating. Positive overflow gives 0x7FFF, negative overflow gives 0x8000, and error=1 in both cases.
  - 001 SUB: A-B, saturating with the same rules and error.
  - 010 NAND: ~(A&B); error=0.
  - 011 XOR: A^B; error=0.
  - 100 PADD: four independent signed 4-bit lane adds. Each lane saturates to 0x7 or 0x8 on overflow. error=1 if any lane saturates.
  - 101 RED: four independent 4-bit lane adds. Each lane keeps its low 4 bits; no carries between lanes, no saturation; error=0.
  - 110, 111: reserved. alu_out=0x0000, error=0. A write with a reserved opcode stores 0x0000.
- Overflow detection: same-sign operands (for SUB, the effective operand ~B) producing an opposite-sign sum. The detector must not rely on the saturated output.
- Simultaneous read and write of the same register: the read returns the old value until the edge.

Decomposition:
- Shared package alu_pkg:
  - opcode enum: OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_PADD, OP_RED.
  - constants DATA_W and REG_IDX_W.
  - saturation constants SAT_POS16=0x7FFF, SAT_NEG16=0x8000, SAT_POS4=0x7, SAT_NEG4=0x8.
- One sub-module: lane_add4. It is a 4-bit carry-lookahead adder with sub input, carry-out and signed overflow outputs.
  - Four instances serve PADD and RED.
  - They are chained through their carries for the 16-bit ADD/SUB.

Test Plan:
- Reset: assert rst=0 at t=0, release, read all 16 indices -> src_data1/src_data2 all 0x0000, error=0.
- Write/read:
  - Preload via ADD/XOR from R0 plus a prior value.
  - Write R3 with opcode XOR where R1=0x1234, R2=0x0000 -> after the edge src_data1 (R3)=0x1234.
  - Writes to R0 leave R0=0x0000.
  - Same-cycle read of R3 returns the old value.
- ADD/SUB saturation:
  - 0x7FFF+0x0001 -> 0x7FFF, error=1.
  - 0x8800+0x8901 -> 0x8000, error=1.
  - SUB 0x8000-0x0001 -> 0x8000, error=1.
  - 0x0000+0x0000 -> 0x0000, error=0.
- PADD:
  - 0x8009+0x9009 -> 0x8008, error=1.
  - 0x0FD8+0x0019 -> 0x0FE8, error=1.
- RED:
  - 0x1111+0x1111 -> 0x2222.
  - 0xF111+0xF111 -> 0xE222, error=0.
- Logic and random:
  - 256 random operand/opcode pairs checked against a reference model: NAND = ~(A&B), XOR = A^B with error=0.
  - Reserved opcodes -> 0x0000, error=0.
